// File: rtl/memreg_pkg.sv
// Shared types and helpers for the multi-port register memory: FSM state,
// default geometry and the byte-lane merge used for write collisions/forwarding.
package memreg_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    localparam int unsigned LANES = 4;
    localparam int unsigned IDX_W = 10;

    // Upper bound for the merge helper; callers zero-extend and truncate.
    localparam int unsigned MAX_WIDTH = 1024;
    localparam int unsigned MAX_LANES = MAX_WIDTH / 8;

    function automatic logic [MAX_WIDTH-1:0] lane_merge(
        input logic [MAX_WIDTH-1:0] old_word,
        input logic [MAX_WIDTH-1:0] new_word,
        input logic [MAX_LANES-1:0] lane_mask
    );
        logic [MAX_WIDTH-1:0] merged;
        merged = old_word;
        for (int i = 0; i < MAX_LANES; i++) begin
            if (lane_mask[i]) merged[i*8 +: 8] = new_word[i*8 +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/memory_reg_mp_if.sv
// Bus bundle for memory_reg_mp: clear control, RW load/store port,
// instruction read port and full-word write port.
interface memory_reg_mp_if #(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned WIDTH         = 32
);
    localparam int unsigned N_LANES = WIDTH / 8;

    logic                     clr_req;
    logic                     ready;
    logic                     rw_req;
    logic                     rw_we;
    logic [N_LANES-1:0]       rw_be;
    logic [ADDRESS_WIDTH-1:0] rw_addr;
    logic [WIDTH-1:0]         rw_wdata;
    logic                     rw_rvalid;
    logic [WIDTH-1:0]         rw_rdata;
    logic                     rd_en;
    logic [ADDRESS_WIDTH-1:0] rd_addr;
    logic                     rd_valid;
    logic [WIDTH-1:0]         rd_data;
    logic                     wr_en;
    logic [ADDRESS_WIDTH-1:0] wr_addr;
    logic [WIDTH-1:0]         wr_data;

    modport master (
        output clr_req, rw_req, rw_we, rw_be, rw_addr, rw_wdata,
               rd_en, rd_addr, wr_en, wr_addr, wr_data,
        input  ready, rw_rvalid, rw_rdata, rd_valid, rd_data
    );

    modport slave (
        input  clr_req, rw_req, rw_we, rw_be, rw_addr, rw_wdata,
               rd_en, rd_addr, wr_en, wr_addr, wr_data,
        output ready, rw_rvalid, rw_rdata, rd_valid, rd_data
    );

endinterface

// File: rtl/memreg_bank.sv
// Word storage with two lane-masked write ports (port B wins per lane on a
// same-word collision) and two asynchronous read ports.
module memreg_bank #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 32,
    localparam int unsigned N_LANES = WIDTH / 8,
    localparam int unsigned IW      = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               a_we_i,
    input  logic [IW-1:0]      a_idx_i,
    input  logic [N_LANES-1:0] a_be_i,
    input  logic [WIDTH-1:0]   a_data_i,
    input  logic               b_we_i,
    input  logic [IW-1:0]      b_idx_i,
    input  logic [N_LANES-1:0] b_be_i,
    input  logic [WIDTH-1:0]   b_data_i,
    input  logic [IW-1:0]      r0_idx_i,
    output logic [WIDTH-1:0]   r0_data_o,
    input  logic [IW-1:0]      r1_idx_i,
    output logic [WIDTH-1:0]   r1_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // NOTE: the array has no reset; the clear sweep zeroes it instead, which keeps it mappable to RAM.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_LANES; i++) begin
            if (a_we_i && a_be_i[i]) mem_q[a_idx_i][i*8 +: 8] <= a_data_i[i*8 +: 8];
            if (b_we_i && b_be_i[i]) mem_q[b_idx_i][i*8 +: 8] <= b_data_i[i*8 +: 8];
        end
    end

    assign r0_data_o = mem_q[r0_idx_i];
    assign r1_data_o = mem_q[r1_idx_i];

endmodule

// File: rtl/memory_reg_mp.sv
// Three-port self-clearing word memory. Define MEMREG_FWD_EN for write-first
// forwarding of same-cycle writes to loads/reads; default is read-first.
module memory_reg_mp
    import memreg_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DEPTH         = 1 << IDX_W,
    parameter int unsigned WIDTH         = LANES * 8
) (
    input  logic            clk,
    input  logic            reset_n,
    memory_reg_mp_if.slave  bus
);

    localparam int unsigned N_LANES = WIDTH / 8;
    localparam int unsigned IW      = $clog2(DEPTH);
    localparam int unsigned OFF_W   = $clog2(N_LANES);

    typedef logic [WIDTH-1:0]         word_t;
    typedef logic [IW-1:0]            idx_t;
    typedef logic [ADDRESS_WIDTH-1:0] addr_t;

    function automatic logic in_range(input addr_t a);
        return (a >> (OFF_W + IW)) == '0;
    endfunction

    function automatic idx_t word_idx(input addr_t a);
        return idx_t'(a >> OFF_W);
    endfunction

    function automatic word_t merge(input word_t o, input word_t n, input logic [N_LANES-1:0] m);
        return word_t'(lane_merge(MAX_WIDTH'(o), MAX_WIDTH'(n), MAX_LANES'(m)));
    endfunction

    state_e state_q;
    idx_t   clr_cnt_q;
    logic   rw_rvalid_q, rd_valid_q;
    word_t  rw_rdata_q, rd_data_q;
    word_t  rw_rdata_d, rd_data_d;
    word_t  rw_old, rd_old;

    logic run, rw_ld, rw_st, rd_acc, wr_acc;
    idx_t rw_idx, rd_idx, wr_idx;

    assign run    = (state_q == RUN);
    assign rw_idx = word_idx(bus.rw_addr);
    assign rd_idx = word_idx(bus.rd_addr);
    assign wr_idx = word_idx(bus.wr_addr);
    assign rw_ld  = run & bus.rw_req & ~bus.rw_we;
    assign rw_st  = run & bus.rw_req & bus.rw_we & in_range(bus.rw_addr);
    assign rd_acc = run & bus.rd_en;
    assign wr_acc = run & bus.wr_en & in_range(bus.wr_addr);

    // Port A carries the clear sweep while clearing and the full-word write port in RUN.
    memreg_bank #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_bank (
        .clk       (clk),
        .a_we_i    (~run | wr_acc),
        .a_idx_i   (run ? wr_idx : clr_cnt_q),
        .a_be_i    ('1),
        .a_data_i  (run ? bus.wr_data : '0),
        .b_we_i    (rw_st),
        .b_idx_i   (rw_idx),
        .b_be_i    (bus.rw_be),
        .b_data_i  (bus.rw_wdata),
        .r0_idx_i  (rw_idx),
        .r0_data_o (rw_old),
        .r1_idx_i  (rd_idx),
        .r1_data_o (rd_old)
    );

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        rw_rdata_d = rw_old;
        rd_data_d  = rd_old;
`ifdef MEMREG_FWD_EN
        if (wr_acc && wr_idx == rw_idx) rw_rdata_d = bus.wr_data;
        if (wr_acc && wr_idx == rd_idx) rd_data_d  = bus.wr_data;
        if (rw_st && rw_idx == rd_idx)  rd_data_d  = merge(rd_data_d, bus.rw_wdata, bus.rw_be);
`endif
        if (!in_range(bus.rw_addr)) rw_rdata_d = '0;
        if (!in_range(bus.rd_addr)) rd_data_d  = '0;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
        end else begin
            case (state_q)
                CLEAR: begin
                    clr_cnt_q <= clr_cnt_q + idx_t'(1);
                    if (clr_cnt_q == idx_t'(DEPTH - 1)) state_q <= RUN;
                end
                RUN: begin
                    if (bus.clr_req) begin
                        state_q   <= CLEAR;
                        clr_cnt_q <= '0;
                    end
                end
                default: state_q <= CLEAR;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rw_rvalid_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rw_rdata_q  <= '0;
            rd_data_q   <= '0;
        end else begin
            rw_rvalid_q <= rw_ld;
            rd_valid_q  <= rd_acc;
            if (rw_ld)  rw_rdata_q <= rw_rdata_d;
            if (rd_acc) rd_data_q  <= rd_data_d;
        end
    end

    assign bus.ready     = run;
    assign bus.rw_rvalid = rw_rvalid_q;
    assign bus.rw_rdata  = rw_rdata_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;

endmodule
